fp_op_controller: RTL and testbench

//  Sequencing FSM that drives the control inputs of the single-precision FP datapath.
//  The controlled inputs are smallerExpSrc, shiftRightQtt, operation, normalization_src and shift_src.
//  It consumes the datapath status outputs expDiff, fracResult and carry.
//  It runs one add/sub/mult per start pulse (align, ALU, normalise, round-check) and pulses done when finished.

---
 rtl/fp_op_controller.sv | 198 +++++++++++++++++++
 tb/tb_fp_op_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_controller.sv
//------------------------------------------------------------------------------
// fp_op_controller: sequences align/ALU/normalise/round-check on the FP datapath
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_op_controller #(
    parameter int EXP_W      = 8,
    parameter int FRAC_W     = 27,
    parameter int MAX_RENORM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [EXP_W-1:0]  exp_diff,
    input  logic [FRAC_W-1:0] frac_result,
    input  logic              carry,
    output logic              smaller_exp_src,
    output logic [EXP_W-1:0]  shift_right_qtt,
    output logic [1:0]        operation,
    output logic              normalization_src,
    output logic              shift_src,
    output logic              busy,
    output logic              done,
    output logic              result_latch_en,
    output logic              zero_res,
    output logic              err
);

    localparam int CNT_W = (MAX_RENORM < 1) ? 1 : $clog2(MAX_RENORM + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXP    = 3'd1,
        S_ALU    = 3'd2,
        S_NORM   = 3'd3,
        S_CHK    = 3'd4,
        S_RENORM = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sm_q, sm_d;
    logic [EXP_W-1:0]   qtt_q, qtt_d;
    logic [1:0]         operation_q, operation_d;
    logic               norm_src_q, norm_src_d;
    logic               shift_src_q, shift_src_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               latch_q, latch_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // One extra bit so that negating the most negative exp_diff stays positive.
    logic [EXP_W:0]     mag;

    always_comb begin
        if (exp_diff[EXP_W-1]) begin
            mag = {1'b0, ~exp_diff} + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            mag = {1'b0, exp_diff};
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sm_d        = sm_q;
        qtt_d       = qtt_q;
        operation_d = operation_q;
        norm_src_d  = norm_src_q;
        shift_src_d = shift_src_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        latch_d     = 1'b0;
        zero_d      = zero_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    busy_d = 1'b1;
                    if (op == 2'b11) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        latch_d = 1'b1;
                    end else begin
                        state_d = S_EXP;
                    end
                end
            end
            S_EXP: begin
                sm_d        = ~exp_diff[EXP_W-1];
                qtt_d       = (mag > (EXP_W+1)'(FRAC_W)) ? EXP_W'(FRAC_W) : mag[EXP_W-1:0];
                operation_d = op_q;
                norm_src_d  = 1'b1;
                state_d     = S_ALU;
            end
            S_ALU: begin
                shift_src_d = carry;
                if ((frac_result == '0) && !carry) begin
                    zero_d  = 1'b1;
                    done_d  = 1'b1;
                    latch_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                norm_src_d = 1'b0;
                state_d    = S_CHK;
            end
            S_CHK: begin
                if (frac_result[FRAC_W-1]) begin
                    done_d  = 1'b1;
                    latch_d = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q < CNT_W'(MAX_RENORM)) begin
                    shift_src_d = 1'b1;
                    state_d     = S_RENORM;
                end else begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    latch_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RENORM: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_CHK;
            end
            S_DONE: begin
                busy_d     = 1'b0;
                zero_d     = 1'b0;
                err_d      = 1'b0;
                cnt_d      = '0;
                norm_src_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            sm_q        <= 1'b0;
            qtt_q       <= '0;
            operation_q <= 2'b00;
            norm_src_q  <= 1'b1;
            shift_src_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            latch_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sm_q        <= sm_d;
            qtt_q       <= qtt_d;
            operation_q <= operation_d;
            norm_src_q  <= norm_src_d;
            shift_src_q <= shift_src_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            latch_q     <= latch_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign smaller_exp_src   = sm_q;
    assign shift_right_qtt   = qtt_q;
    assign operation         = operation_q;
    assign normalization_src = norm_src_q;
    assign shift_src         = shift_src_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign result_latch_en   = latch_q;
    assign zero_res          = zero_q;
    assign err               = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_op_controller.sv
//------------------------------------------------------------------------------
// tb_fp_op_controller: directed self-checking bench for fp_op_controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_op_controller;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 27;
    localparam logic [FRAC_W-1:0] C_MSB = 27'h4000000;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [EXP_W-1:0]  exp_diff;
    logic [FRAC_W-1:0] frac_result;
    logic              carry;
    logic              smaller_exp_src;
    logic [EXP_W-1:0]  shift_right_qtt;
    logic [1:0]        operation;
    logic              normalization_src;
    logic              shift_src;
    logic              busy;
    logic              done;
    logic              result_latch_en;
    logic              zero_res;
    logic              err;

    int n_total;
    int n_bad;

    fp_op_controller #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .MAX_RENORM(2)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .op                (op),
        .exp_diff          (exp_diff),
        .frac_result       (frac_result),
        .carry             (carry),
        .smaller_exp_src   (smaller_exp_src),
        .shift_right_qtt   (shift_right_qtt),
        .operation         (operation),
        .normalization_src (normalization_src),
        .shift_src         (shift_src),
        .busy              (busy),
        .done              (done),
        .result_latch_en   (result_latch_en),
        .zero_res          (zero_res),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise start for one cycle; on return the bench sits in cycle N+1.
    task automatic launch(input logic [1:0] o, input logic [7:0] ed,
                          input logic [FRAC_W-1:0] fr, input logic cy);
        op          = o;
        exp_diff    = ed;
        frac_result = fr;
        carry       = cy;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    initial begin
        logic saw_done;
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        op          = 2'b00;
        exp_diff    = '0;
        frac_result = '0;
        carry       = 1'b0;
        tick(2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_norm_src", {31'd0, normalization_src}, 32'd1);
        check("rst_qtt", {24'd0, shift_right_qtt}, 32'd0);
        check("rst_flags", {29'd0, err, zero_res, result_latch_en}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: add, B has smaller exponent
        launch(2'b00, 8'h03, C_MSB, 1'b0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("t1_sm", {31'd0, smaller_exp_src}, 32'd1);
        check("t1_qtt", {24'd0, shift_right_qtt}, 32'd3);
        check("t1_operation", {30'd0, operation}, 32'd0);
        tick(2);
        check("t1_norm_src_chk", {31'd0, normalization_src}, 32'd0);
        check("t1_done_early", {31'd0, done}, 32'd0);
        tick(1);
        check("t1_done", {30'd0, done, result_latch_en}, 32'd3);
        check("t1_flags", {29'd0, err, zero_res, busy}, 32'd1);
        tick(1);
        check("t1_after", {29'd0, busy, done, normalization_src}, 32'd1);

        // 2: sub, A has smaller exponent, carry out
        launch(2'b01, 8'hFB, C_MSB, 1'b1);
        tick(1);
        check("t2_sm", {31'd0, smaller_exp_src}, 32'd0);
        check("t2_qtt", {24'd0, shift_right_qtt}, 32'd5);
        check("t2_operation", {30'd0, operation}, 32'd1);
        tick(1);
        check("t2_shift_src", {31'd0, shift_src}, 32'd1);
        tick(2);
        check("t2_done", {30'd0, done, err}, 32'd2);
        tick(1);
        carry = 1'b0;

        // 3: saturation and zero difference
        launch(2'b00, 8'h80, C_MSB, 1'b0);
        tick(1);
        check("t3_qtt_80", {24'd0, shift_right_qtt}, 32'd27);
        tick(4);
        launch(2'b00, 8'h1E, C_MSB, 1'b0);
        tick(1);
        check("t3_qtt_1e", {24'd0, shift_right_qtt}, 32'd27);
        tick(4);
        launch(2'b00, 8'h00, C_MSB, 1'b0);
        tick(1);
        check("t3_qtt_00", {23'd0, smaller_exp_src, shift_right_qtt}, 32'h100);
        tick(4);

        // 4: zero fraction, then illegal op
        launch(2'b00, 8'h02, '0, 1'b0);
        tick(1);
        check("t4_zero_early", {31'd0, done}, 32'd0);
        tick(1);
        check("t4_zero_done", {29'd0, done, zero_res, err}, 32'd6);
        tick(1);
        check("t4_zero_clear", {30'd0, busy, zero_res}, 32'd0);
        launch(2'b11, 8'h02, C_MSB, 1'b0);
        check("t4_illegal", {29'd0, done, err, busy}, 32'd7);
        tick(1);
        check("t4_illegal_clear", {29'd0, done, err, busy}, 32'd0);

        // 5a: MSB never set -> two renorm passes then err
        launch(2'b00, 8'h01, 27'h1, 1'b0);
        tick(4);
        check("t5_renorm_shift", {31'd0, shift_src}, 32'd1);
        tick(3);
        check("t5_done_early", {31'd0, done}, 32'd0);
        tick(1);
        check("t5_err_done", {29'd0, done, err, zero_res}, 32'd6);
        tick(1);

        // 5b: MSB rises on the second check
        launch(2'b00, 8'h01, 27'h1, 1'b0);
        tick(5);
        frac_result = C_MSB;
        tick(1);
        check("t5b_done", {30'd0, done, err}, 32'd2);
        tick(1);

        // 6: async reset in NORM, no done afterwards
        launch(2'b00, 8'h04, C_MSB, 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {30'd0, busy, normalization_src}, 32'd1);
        check("t6_rst_qtt", {24'd0, shift_right_qtt}, 32'd0);
        #3;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            saw_done = saw_done | done | busy;
        end
        check("t6_no_done", {31'd0, saw_done}, 32'd0);

        // 6b: start while busy ignored; back-to-back start accepted
        launch(2'b00, 8'h02, C_MSB, 1'b0);
        tick(1);
        op    = 2'b11;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        op    = 2'b00;
        tick(2);
        check("t6_busy_ignored", {30'd0, done, err}, 32'd2);
        tick(1);
        check("t6_idle", {31'd0, busy}, 32'd0);
        launch(2'b00, 8'h02, C_MSB, 1'b0);
        check("t6_b2b_busy", {31'd0, busy}, 32'd1);
        tick(4);
        check("t6_b2b_done", {30'd0, done, err}, 32'd2);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
